// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-to-parallel frame controller.
package deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // The counter must hold DATA_WIDTH so that the "last bit" compare fits.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/deser_shift.sv
// MSB-first shift register. A clear that coincides with a shift seeds the register with din.
module deser_shift #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (clr) begin
            shift_d = en ? {{(DATA_WIDTH-1){1'b0}}, din} : '0;
        end else if (en) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/deser_frame_ctrl.sv
// Frame controller: sof alignment, bit counting, one-word output buffer and sticky error flags.
module deser_frame_ctrl
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  sof,
    input  logic                  frame_end,
    input  logic                  err_clr,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  overflow,
    output logic                  sync_err
);

    localparam int             CW       = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  sync_err_q, sync_err_d;

    logic                  shift_clr;
    logic                  shift_en;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  word_done;
    logic                  sync_set;
    logic                  ovf_set;
    logic [DATA_WIDTH-1:0] word;

    deser_shift #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift (
        .clk    (clk),
        .resetn (resetn),
        .clr    (shift_clr),
        .en     (shift_en),
        .din    (din),
        .q      (shift_q)
    );

    // The completed word includes the bit arriving this cycle.
    assign word = {shift_q[DATA_WIDTH-2:0], din};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_clr = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        sync_set  = 1'b0;

        if (frame_end) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sync_set  = (bit_cnt_q != '0);
        end else if (din_valid && sof) begin
            state_d   = SHIFT;
            shift_clr = 1'b1;
            shift_en  = 1'b1;
            bit_cnt_d = CNT_ONE;
            sync_set  = (state_q == SHIFT) && (bit_cnt_q != '0);
        end else if (din_valid && (state_q == SHIFT)) begin
            shift_en = 1'b1;
            if (bit_cnt_q == CNT_LAST) begin
                word_done = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
        end
    end

    // A finished word may replace the buffered one only when it is leaving this cycle.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ovf_set      = 1'b0;

        if (word_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        overflow_d = ovf_set  | (overflow_q & ~err_clr);
        sync_err_d = sync_set | (sync_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == SHIFT);
    assign overflow   = overflow_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Directed and randomized bench for deser_frame_ctrl against a bit-queue reference model.
module tb_deser_frame_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         sof = 1'b0;
    logic         frame_end = 1'b0;
    logic         err_clr = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         overflow;
    logic         sync_err;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: the partial word is kept as a queue of received bits.
    bit           m_active = 1'b0;
    bit           m_bits[$];
    logic [W-1:0] m_dout = '0;
    logic         m_valid = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_serr = 1'b0;

    deser_frame_ctrl #(
        .DATA_WIDTH(W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .frame_end  (frame_end),
        .err_clr    (err_clr),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .overflow   (overflow),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the rules of one clock edge to the model, using the inputs currently driven.
    task automatic model_edge();
        bit           serr_set;
        bit           ovf_set;
        bit           done;
        int unsigned  value;
        serr_set = 1'b0;
        ovf_set  = 1'b0;
        done     = 1'b0;
        value    = 0;
        if (!resetn) begin
            m_active = 1'b0;
            m_bits.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_serr  = 1'b0;
            return;
        end
        if (frame_end) begin
            if (m_bits.size() != 0) serr_set = 1'b1;
            m_bits.delete();
            m_active = 1'b0;
        end else if (din_valid && sof) begin
            if (m_bits.size() != 0) serr_set = 1'b1;
            m_bits.delete();
            m_bits.push_back(din);
            m_active = 1'b1;
        end else if (din_valid && m_active) begin
            m_bits.push_back(din);
            if (m_bits.size() == W) begin
                foreach (m_bits[i]) value = value * 2 + int'(m_bits[i]);
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || dout_ready) begin
                m_dout  = W'(value);
                m_valid = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (m_valid && dout_ready) begin
            m_valid = 1'b0;
        end
        m_ovf  = ovf_set  || (m_ovf  && !err_clr);
        m_serr = serr_set || (m_serr && !err_clr);
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".dout"},       dout,              m_dout);
        check({tag, ".dout_valid"}, W'(dout_valid),    W'(m_valid));
        check({tag, ".busy"},       W'(busy),          W'(m_active));
        check({tag, ".overflow"},   W'(overflow),      W'(m_ovf));
        check({tag, ".sync_err"},   W'(sync_err),      W'(m_serr));
    endtask

    task automatic drive(input logic v, input logic d, input logic s, input logic fe,
                         input logic ec, input logic rdy);
        din_valid  = v;
        din        = d;
        sof        = s;
        frame_end  = fe;
        err_clr    = ec;
        dout_ready = rdy;
    endtask

    task automatic idle(input int n, input logic rdy, input string tag);
        repeat (n) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy);
            cycle(tag);
        end
    endtask

    // Send the top nbits of w MSB-first; optional random idle gaps before each bit.
    task automatic send_word(input logic [W-1:0] w, input bit with_sof, input bit gaps,
                             input logic rdy, input int nbits, input string tag);
        for (int i = W - 1; i >= W - nbits; i--) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, rdy);
                    cycle({tag, ".gap"});
                end
            end
            drive(1'b1, w[i], with_sof && (i == W - 1), 1'b0, 1'b0, rdy);
            cycle(tag);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic end_frame(input logic rdy, input string tag);
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, rdy);
        cycle(tag);
    endtask

    initial begin
        // Reset state
        resetn = 1'b0;
        idle(2, 1'b0, "reset");
        resetn = 1'b1;
        idle(1, 1'b1, "post_reset");

        // Single word, contiguous bits, consumer ready
        send_word(16'hA5C3, 1'b1, 1'b0, 1'b1, W, "a5c3");
        idle(2, 1'b1, "a5c3.drain");
        end_frame(1'b1, "a5c3.end");

        // Two words after one sof with gaps, consumer ready
        send_word(16'h1234, 1'b1, 1'b1, 1'b1, W, "w1234");
        send_word(16'hFFFF, 1'b0, 1'b1, 1'b1, W, "wffff");
        idle(2, 1'b1, "pair.drain");
        end_frame(1'b1, "pair.end");

        // Same two words with the consumer stalled -> overflow
        send_word(16'h1234, 1'b1, 1'b1, 1'b0, W, "stall1");
        send_word(16'hFFFF, 1'b0, 1'b1, 1'b0, W, "stall2");
        idle(1, 1'b0, "stall.hold");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("stall.errclr");
        idle(3, 1'b0, "stall.hold2");
        idle(2, 1'b1, "stall.release");
        end_frame(1'b1, "stall.end");

        // Resync after 5 bits, then a full word
        send_word(16'hB800, 1'b1, 1'b0, 1'b1, 5, "partial5");
        send_word(16'h00FF, 1'b1, 1'b0, 1'b1, W, "resync");
        idle(2, 1'b1, "resync.drain");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("resync.errclr");

        // frame_end mid-word, then at a word boundary
        send_word(16'h6E00, 1'b1, 1'b0, 1'b1, 7, "partial7");
        end_frame(1'b1, "fe.mid");
        idle(1, 1'b1, "fe.idle");
        end_frame(1'b1, "fe.zero");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("fe.errclr");

        // err_clr in the same cycle as a resync: the set wins
        send_word(16'hE000, 1'b1, 1'b0, 1'b1, 3, "partial3");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle("clr_vs_set");
        idle(1, 1'b1, "clr_vs_set.hold");
        end_frame(1'b1, "clr_vs_set.end");

        // Reset mid-word with a word pending
        send_word(16'h5A5A, 1'b1, 1'b0, 1'b0, W, "pend");
        send_word(16'hC3C3, 1'b0, 1'b0, 1'b0, 9, "pend.partial");
        resetn = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("midreset");
        resetn = 1'b1;
        send_word(16'h9E37, 1'b1, 1'b0, 1'b1, W, "fresh");
        idle(2, 1'b1, "fresh.drain");

        // Randomized traffic including occasional resets
        for (int n = 0; n < 400; n++) begin
            resetn = ($urandom_range(0, 99) != 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/deser_frame_ctrl.md
# deser_frame_ctrl

Frame controller that sequences a serial-to-parallel shift register. It qualifies incoming bits, aligns words on a start-of-frame marker, and counts bits. Each completed word is presented on a valid/ready output port. It also flags framing errors and output overflow. It sits between a serial link front end and the parallel word consumer.

## Interface
- DATA_WIDTH, 16, word width in bits; must be ≥ 2
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- din  in  1  serial data bit
- din_valid  in  1  qualifies din this cycle
- sof  in  1  start of frame; meaningful only with din_valid=1; marks din as MSB of a new word
- frame_end  in  1  terminates the current frame; single-cycle pulse
- err_clr  in  1  clears sticky error flags
- dout_ready  in  1  consumer accepts dout
- dout  out  DATA_WIDTH  completed word; MSB = first bit received
- dout_valid  out  1  dout holds an unconsumed word
- busy  out  1  controller is in SHIFT state
- overflow  out  1  sticky: a completed word was dropped
- sync_err  out  1  sticky: a partial word was discarded

## Operation
- States: IDLE, SHIFT.
- IDLE: din_valid without sof is ignored. sof=1 with din_valid=1 clears the shift register, shifts din in, sets bit_cnt=1, and goes to SHIFT.
- SHIFT: each din_valid shifts din into the LSB (contents move toward the MSB) and increments bit_cnt.
- Word completion: when bit DATA_WIDTH is accepted, the word is complete and bit_cnt wraps to 0. The state stays SHIFT, so the following bits form the next word with no new sof needed.
- Resync: sof=1 with din_valid=1 in SHIFT and bit_cnt≠0 sets sync_err, discards the partial word, and restarts at bit_cnt=1 with din as MSB. With bit_cnt=0 it is a clean restart and raises no error.
- frame_end: goes to IDLE and sets bit_cnt=0. If bit_cnt≠0, it also sets sync_err.
- Output register:
  - A completed word loads dout and sets dout_valid, if dout_valid=0 or dout_ready=1 that cycle.
  - Otherwise the new word is dropped, overflow is set, and dout is unchanged.
  - A transfer occurs when dout_valid && dout_ready. dout_valid clears on a transfer unless a new word loads in the same cycle.
- err_clr clears overflow and sync_err. If a new error event occurs in the same cycle, the set wins.
- Priority within a cycle: resetn > frame_end > sof > plain shift. A din_valid bit arriving together with frame_end is discarded.
- bit_cnt width is $clog2(DATA_WIDTH+1). It never exceeds DATA_WIDTH-1 after a wrap.

## Timing
- Reset values: dout=0, dout_valid=0, busy=0, overflow=0, sync_err=0, state IDLE, bit_cnt=0, shift register 0.
- Latency: the last bit is accepted at edge N; dout/dout_valid are visible after edge N. There are no other pipeline stages.
- busy rises the cycle after the sof bit is accepted, and falls the cycle after frame_end.
- Sticky flags are set on the edge where the event is sampled and are visible the next cycle.
- Reset asserted mid-word discards all state. Outputs read reset values after the edge.
- dout is stable while dout_valid=1 && dout_ready=0.
- Throughput: one bit per cycle sustained; back-to-back words with dout_ready=1 never overflow.

## Structure
- Package deser_pkg holds:
  - the state enum typedef (IDLE, SHIFT)
  - a width function for bit_cnt
- Sub-module deser_shift: DATA_WIDTH shift register with ports clk, resetn, clr, en, din, q. clr has priority over en and loads {0…0, din} when en is also set.
- The controller instantiates deser_shift once. It owns the FSM, bit counter, output register and flags.

## Test plan
- Reset, then 0xA5C3 sent MSB-first over 16 consecutive din_valid cycles, sof on the first bit, dout_ready=1 → dout=16'hA5C3 with dout_valid high for exactly 1 cycle, beginning after the 16th bit's edge; no errors.
- Words 0x1234 then 0xFFFF, one sof only, din_valid randomly gapped, dout_ready=1 → two beats in order, 0x1234 then 0xFFFF; busy stays 1.
- Same two words with dout_ready=0 → dout holds 0x1234, overflow=1 after the 16th bit of word two. After err_clr, overflow=0 and dout is still 0x1234 until dout_ready.
- sof after 5 bits, then 0x00FF sent fully → sync_err=1, next beat dout=16'h00FF.
- frame_end after 7 bits → IDLE, busy=0, sync_err=1, no beat. frame_end at bit_cnt=0 → sync_err unchanged. err_clr together with a resync → sync_err stays 1.
- resetn low after 9 bits with dout_valid=1 → all outputs 0 next cycle; a fresh sof word completes correctly afterward.
